// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO read-side serializer.
package fifo_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Symbol counter width; a single-symbol word still needs a 1-bit counter.
  function automatic int cnt_width(input int ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_rd_serializer.sv
// Pops words from a show-ahead FIFO and streams them out as OWIDTH-bit symbols,
// flagging the first and last symbol of every word.
module fifo_rd_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int OWIDTH    = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_req_o,
  output logic [OWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic              busy_o
);

  localparam int RATIO = DWIDTH / OWIDTH;
  localparam int CNT_W = cnt_width(RATIO);
  localparam int NSYM  = 2 ** CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  generate
    if (DWIDTH % OWIDTH != 0) begin : g_bad_ratio
      $error("fifo_rd_serializer: DWIDTH must be a multiple of OWIDTH");
    end
  endgenerate

  state_e                       state, state_nxt;
  logic [CNT_W-1:0]             cnt;
  logic [DWIDTH-1:0]            hold;
  logic [NSYM-1:0][OWIDTH-1:0]  syms;
  logic                         accept, last, load;

  assign accept        = (state == SHIFT) && ready_i;
  assign last          = accept && (cnt == LAST_CNT);
  // Refill on the last accept so consecutive words run without a bubble.
  assign load          = !srst_i && !fifo_empty_i && ((state == IDLE) || last);
  assign fifo_rd_req_o = load;

  always_ff @(posedge clk_i) begin
    if (srst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = load ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state == SHIFT);
    sop_o   = (state == SHIFT) && (cnt == '0);
    eop_o   = (state == SHIFT) && (cnt == LAST_CNT);
    busy_o  = (state == SHIFT) || load;
    data_o  = syms[cnt];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      hold <= '0;
      cnt  <= '0;
    end else if (load) begin
      hold <= fifo_q_i;
      cnt  <= '0;
    end else if (last) begin
      cnt  <= '0;
    end else if (accept) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Symbol table indexed by cnt; entries past RATIO pad the power-of-two range.
  generate
    for (genvar i = 0; i < NSYM; i++) begin : g_sym
      if (i >= RATIO) begin : g_pad
        assign syms[i] = '0;
      end else if (MSB_FIRST) begin : g_msb
        assign syms[i] = hold[DWIDTH-1-i*OWIDTH -: OWIDTH];
      end else begin : g_lsb
        assign syms[i] = hold[i*OWIDTH +: OWIDTH];
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed checks of fifo_rd_serializer: MSB/LSB-first 8->2 and pass-through 8->8.
module tb_fifo_rd_serializer;

  logic       clk, srst, ready;
  logic [7:0] fq;
  logic       emp_a, emp_b, emp_c;
  logic       rd_a, rd_b, rd_c;
  logic [1:0] d_a, d_b;
  logic [7:0] d_c;
  logic       v_a, v_b, v_c, s_a, s_b, s_c, e_a, e_b, e_c, b_a, b_b, b_c;
  int         checks = 0;
  int         errors = 0;

  fifo_rd_serializer #(.DWIDTH(8), .OWIDTH(2), .MSB_FIRST(1'b1)) u_a (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(fq), .fifo_empty_i(emp_a), .fifo_rd_req_o(rd_a),
    .data_o(d_a), .valid_o(v_a), .ready_i(ready), .sop_o(s_a), .eop_o(e_a), .busy_o(b_a));

  fifo_rd_serializer #(.DWIDTH(8), .OWIDTH(2), .MSB_FIRST(1'b0)) u_b (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(fq), .fifo_empty_i(emp_b), .fifo_rd_req_o(rd_b),
    .data_o(d_b), .valid_o(v_b), .ready_i(ready), .sop_o(s_b), .eop_o(e_b), .busy_o(b_b));

  fifo_rd_serializer #(.DWIDTH(8), .OWIDTH(8), .MSB_FIRST(1'b1)) u_c (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(fq), .fifo_empty_i(emp_c), .fifo_rd_req_o(rd_c),
    .data_o(d_c), .valid_o(v_c), .ready_i(ready), .sop_o(s_c), .eop_o(e_c), .busy_o(b_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string tag, input logic v, input logic [1:0] d,
                       input logic s, input logic e, input logic r);
    chk({tag, ".valid"}, 32'(v_a), 32'(v));
    if (v) chk({tag, ".data"}, 32'(d_a), 32'(d));
    chk({tag, ".sop"}, 32'(s_a), 32'(s));
    chk({tag, ".eop"}, 32'(e_a), 32'(e));
    chk({tag, ".rd"},  32'(rd_a), 32'(r));
  endtask

  task automatic exp_b(input string tag, input logic v, input logic [1:0] d,
                       input logic s, input logic e, input logic r);
    chk({tag, ".valid"}, 32'(v_b), 32'(v));
    if (v) chk({tag, ".data"}, 32'(d_b), 32'(d));
    chk({tag, ".sop"}, 32'(s_b), 32'(s));
    chk({tag, ".eop"}, 32'(e_b), 32'(e));
    chk({tag, ".rd"},  32'(rd_b), 32'(r));
  endtask

  task automatic exp_c(input string tag, input logic v, input logic [7:0] d,
                       input logic s, input logic e, input logic r);
    chk({tag, ".valid"}, 32'(v_c), 32'(v));
    if (v) chk({tag, ".data"}, 32'(d_c), 32'(d));
    chk({tag, ".sop"}, 32'(s_c), 32'(s));
    chk({tag, ".eop"}, 32'(e_c), 32'(e));
    chk({tag, ".rd"},  32'(rd_c), 32'(r));
  endtask

  initial begin
    srst = 1'b1; ready = 1'b0; fq = 8'h00;
    emp_a = 1'b1; emp_b = 1'b1; emp_c = 1'b1;

    // Reset state, and no pop while reset is asserted even with data waiting
    nxt(); nxt();
    exp_a("rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.data_a", 32'(d_a), 32'd0);
    chk("rst.busy_a", 32'(b_a), 32'd0);
    chk("rst.valid_b", 32'(v_b), 32'd0);
    chk("rst.valid_c", 32'(v_c), 32'd0);
    emp_a = 1'b0; fq = 8'hB4; ready = 1'b1;
    #1 chk("rst.no_pop", 32'(rd_a), 32'd0);

    // Single word 0xB4, MSB first -> 2,3,1,0
    nxt(); srst = 1'b0;
    #1 exp_a("t1.pop", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("t1.busy_pop", 32'(b_a), 32'd1);
    nxt(); emp_a = 1'b1;
    #1 exp_a("t1.s0", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    nxt(); exp_a("t1.s1", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t1.s2", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t1.s3", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    nxt(); exp_a("t1.idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("t1.busy_idle", 32'(b_a), 32'd0);

    // Back-to-back 0xB4, 0x1E -> 2,3,1,0,0,1,3,2 with no gap
    nxt(); emp_a = 1'b0; fq = 8'hB4;
    #1 exp_a("t2.pop0", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    nxt(); fq = 8'h1E;
    #1 exp_a("t2.s0", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    nxt(); exp_a("t2.s1", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t2.s2", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t2.s3", 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    nxt(); emp_a = 1'b1;
    #1 exp_a("t2.s4", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    nxt(); exp_a("t2.s5", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t2.s6", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t2.s7", 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    nxt(); exp_a("t2.idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Backpressure on the second symbol, next word already waiting
    nxt(); emp_a = 1'b0; fq = 8'hB4;
    #1 exp_a("t3.pop0", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    nxt(); fq = 8'h1E;
    #1 exp_a("t3.s0", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    nxt(); ready = 1'b0;
    #1 exp_a("t3.stall0", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t3.stall1", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t3.stall2", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); ready = 1'b1;
    #1 exp_a("t3.s1", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t3.s2", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t3.s3", 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    nxt(); emp_a = 1'b1;
    #1 exp_a("t3.s4", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    nxt(); exp_a("t3.s5", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t3.s6", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t3.s7", 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    nxt(); exp_a("t3.idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-word: rest of 0xB4 dropped, queued 0x1E streams from sop
    nxt(); emp_a = 1'b0; fq = 8'hB4;
    #1 exp_a("t5.pop0", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    nxt(); fq = 8'h1E;
    #1 exp_a("t5.s0", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    nxt(); exp_a("t5.s1", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); srst = 1'b1;
    #1 chk("t5.rst_no_pop", 32'(rd_a), 32'd0);
    nxt(); srst = 1'b0;
    #1 exp_a("t5.after_rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("t5.data_rst", 32'(d_a), 32'd0);
    nxt(); emp_a = 1'b1;
    #1 exp_a("t5.s4", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    nxt(); exp_a("t5.s5", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t5.s6", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); exp_a("t5.s7", 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    nxt(); exp_a("t5.idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // LSB first, 0xB4 -> 0,1,3,2
    nxt(); emp_b = 1'b0; fq = 8'hB4;
    #1 exp_b("t4.pop", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    nxt(); emp_b = 1'b1;
    #1 exp_b("t4.s0", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    nxt(); exp_b("t4.s1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    nxt(); exp_b("t4.s2", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    nxt(); exp_b("t4.s3", 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    nxt(); exp_b("t4.idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("t4.busy_idle", 32'(b_b), 32'd0);

    // Full-width symbols: one symbol per word, sop=eop, pop on every accept
    nxt(); emp_c = 1'b0; fq = 8'h55;
    #1 exp_c("t6.pop0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    nxt(); fq = 8'hAA;
    #1 exp_c("t6.w0", 1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    nxt(); emp_c = 1'b1;
    #1 exp_c("t6.w1", 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
    nxt(); exp_c("t6.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t6.busy_idle", 32'(b_c), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
